ps2_keyboard_port: RTL

- Memory-mapped PS/2 keyboard receiver. The CPU's polling loop reads it with lw at 0xA0000000.
- Deserialises 11-bit PS/2 device-to-host frames (make and break codes), buffers bytes in a small FIFO, and presents a status/data word to the CPU.
- Sits on the I/O read path of the single-cycle CPU. Address decode outside the block asserts io_rd for loads to 0xA0000000.
- The CPU loop tests bit 8 (ready), uses bits 7:0 as the scan code, and the load pops the byte.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_rx_fifo.sv | 49 ++++
 rtl/ps2_keyboard_port.sv | 119 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard port: status word layout, frame length
// and the load address the external decoder matches.
package ps2_pkg;

   localparam int READY_BIT  = 8;
   localparam int OVF_BIT    = 9;
   localparam int FERR_BIT   = 10;
   localparam int FRAME_BITS = 11;
   localparam int BITCNT_W   = 4;

   localparam logic [31:0] PS2_PORT_ADDR = 32'hA000_0000;

   // True when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous byte FIFO for received scan codes; head is visible without a pop.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_AW = 3
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (FIFO_AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push = push & (~full | do_pop) & clrn;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/ps2_keyboard_port.sv
// PS/2 device-to-host receiver with scan-code FIFO, read by the CPU as one
// status/data word; a load pops the head byte and clears the sticky flags.
module ps2_keyboard_port
   import ps2_pkg::*;
#(
   parameter int FIFO_AW        = 3,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        io_rd,
   output logic [31:0] io_data
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic                ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
   logic                ps2_data_p0, ps2_data_p1;
   logic                fall;
   logic [BITCNT_W-1:0] bitcnt;
   logic [7:0]          shreg;
   logic                parity_bit;
   logic [TW-1:0]       tcnt;
   logic                frame_err;
   logic                overflow;
   logic                frame_done;
   logic                frame_ok;
   logic                push;
   logic                ferr_evt;
   logic                ovf_evt;
   logic                pop;
   logic                full;
   logic                empty;
   logic [7:0]          head;

   assign fall       = ps2_clk_p2 & ~ps2_clk_p1;
   assign frame_done = fall && (bitcnt == BITCNT_W'(FRAME_BITS - 1));
   assign frame_ok   = odd_parity_ok(shreg, parity_bit) & ps2_data_p1;
   assign push       = frame_done & frame_ok;
   assign ferr_evt   = frame_done & ~frame_ok;
   assign pop        = io_rd & ~empty;
   assign ovf_evt    = push & full & ~pop;

   // Synchronisers, deserialiser, timeout and sticky status flags
   always_ff @(posedge clk) begin
      if (!clrn) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_clk_p2  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
         bitcnt      <= '0;
         shreg       <= '0;
         parity_bit  <= 1'b0;
         tcnt        <= '0;
         frame_err   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         ps2_clk_p0  <= ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_clk_p2  <= ps2_clk_p1;
         ps2_data_p0 <= ps2_data;
         ps2_data_p1 <= ps2_data_p0;

         if (fall) begin
            tcnt <= '0;
            if (bitcnt == '0) begin
               // A high start bit is line noise; stay aligned on the next fall.
               if (!ps2_data_p1) bitcnt <= BITCNT_W'(1);
            end else if (bitcnt <= BITCNT_W'(8)) begin
               shreg  <= {ps2_data_p1, shreg[7:1]};
               bitcnt <= bitcnt + 1'b1;
            end else if (bitcnt == BITCNT_W'(9)) begin
               parity_bit <= ps2_data_p1;
               bitcnt     <= bitcnt + 1'b1;
            end else begin
               bitcnt <= '0;
            end
         end else if (bitcnt != '0) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               bitcnt <= '0;
               tcnt   <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end

         // Same-cycle events win over the read-clear.
         frame_err <= (frame_err & ~io_rd) | ferr_evt;
         overflow  <= (overflow & ~io_rd) | ovf_evt;
      end
   end

   ps2_rx_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .clrn  (clrn),
      .push  (push),
      .pop   (pop),
      .din   (shreg),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_comb begin
      io_data            = '0;
      io_data[FERR_BIT]  = frame_err;
      io_data[OVF_BIT]   = overflow;
      io_data[READY_BIT] = ~empty;
      io_data[7:0]       = empty ? 8'h00 : head;
   end

endmodule
